// File: rtl/bsg_wormhole_router_input_control_vc.sv
// ---------------------------------------------------------------------------
// bsg_wormhole_router_input_control_vc
//
// Wormhole control for one router input with several virtual channels (VCs).
// Each VC tracks its packet independently. A flit at the FIFO head of an idle
// VC is a header. That header drives requests to its decoded output. When it
// is dequeued, the VC loads the payload length into a body counter and
// latches the destination. Body flits count the counter down. The VC emits a
// one-cycle release pulse as the tail leaves. A dequeue while the FIFO head
// is not valid sets a sticky error.
//
// Handshake: a flit moves only when fifo_yumi_i[v] & fifo_v_i[v] in the same
// cycle. yumi without valid is a protocol error and does not move a flit.
//
// Ports (VC v uses slice v of every vector):
//   clk_i, reset_n_i      clock, synchronous active-low reset
//   fifo_v_i              [vc_p]                  FIFO head valid
//   fifo_decoded_dest_i   [vc_p*output_dirs_p]    one-hot dest of head flit
//   fifo_payload_len_i    [vc_p*payload_len_bits_p] header payload length
//   fifo_yumi_i           [vc_p]                  dequeue head flit
//   reqs_o                [vc_p*output_dirs_p]    output requests (headers)
//   dest_r_o              [vc_p*output_dirs_p]    latched dest, 0 when idle
//   detected_header_o     [vc_p]                  head flit is a header
//   release_o             [vc_p]                  tail dequeued this cycle
//   busy_o                [vc_p]                  inside a packet body
//   err_o                 [vc_p]                  sticky protocol error
// ---------------------------------------------------------------------------
module bsg_wormhole_router_input_control_vc #(
  parameter int vc_p               = 2,
  parameter int output_dirs_p      = 4,
  parameter int payload_len_bits_p = 5
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [vc_p-1:0]                    fifo_v_i,
  input  logic [vc_p*output_dirs_p-1:0]      fifo_decoded_dest_i,
  input  logic [vc_p*payload_len_bits_p-1:0] fifo_payload_len_i,
  input  logic [vc_p-1:0]                    fifo_yumi_i,
  output logic [vc_p*output_dirs_p-1:0]      reqs_o,
  output logic [vc_p*output_dirs_p-1:0]      dest_r_o,
  output logic [vc_p-1:0]                    detected_header_o,
  output logic [vc_p-1:0]                    release_o,
  output logic [vc_p-1:0]                    busy_o,
  output logic [vc_p-1:0]                    err_o
);

  localparam int D = output_dirs_p;
  localparam int L = payload_len_bits_p;

  for (genvar v = 0; v < vc_p; v++) begin : g_vc
    logic [L-1:0] r_ctr;
    logic [D-1:0] r_dest;
    logic         r_err;

    logic [D-1:0] w_dest_in;
    logic [L-1:0] w_len_in;
    logic         w_idle;
    logic         w_acc;
    logic         w_last_body;

    assign w_dest_in   = fifo_decoded_dest_i[v*D +: D];
    assign w_len_in    = fifo_payload_len_i[v*L +: L];
    assign w_idle      = (r_ctr == '0);
    assign w_acc       = fifo_yumi_i[v] & fifo_v_i[v];
    assign w_last_body = (r_ctr == L'(1));

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        r_ctr  <= '0;
        r_dest <= '0;
        r_err  <= 1'b0;
      end else begin
        if (w_acc) begin
          if (w_idle) begin
            // A zero-length header is also the tail, so no dest is held.
            r_ctr  <= w_len_in;
            r_dest <= (w_len_in != '0) ? w_dest_in : '0;
          end else begin
            // Only reached with r_ctr != 0, so this cannot underflow.
            r_ctr <= r_ctr - L'(1);
            if (w_last_body) r_dest <= '0;
          end
        end
        if (fifo_yumi_i[v] & ~fifo_v_i[v]) r_err <= 1'b1;
      end
    end

    assign detected_header_o[v] = fifo_v_i[v] & w_idle;
    assign reqs_o[v*D +: D]     = detected_header_o[v] ? w_dest_in : '0;
    assign dest_r_o[v*D +: D]   = r_dest;
    assign release_o[v]         = w_acc & ((w_idle & (w_len_in == '0)) | w_last_body);
    assign busy_o[v]            = ~w_idle;
    assign err_o[v]             = r_err;
  end

endmodule

// File: tb/tb_bsg_wormhole_router_input_control_vc.sv
// ---------------------------------------------------------------------------
// Directed bench for bsg_wormhole_router_input_control_vc with the default
// parameters (2 VCs, 4 directions, 5-bit length). Inputs change 1 ns after
// the rising edge. Outputs are sampled on the falling edge, before the edge
// that consumes the inputs.
// ---------------------------------------------------------------------------
module tb_bsg_wormhole_router_input_control_vc;

  logic       clk;
  logic       reset_n;
  logic [1:0] fifo_v;
  logic [7:0] fifo_dest;
  logic [9:0] fifo_len;
  logic [1:0] fifo_yumi;
  logic [7:0] reqs;
  logic [7:0] dest_r;
  logic [1:0] det;
  logic [1:0] rel;
  logic [1:0] busy;
  logic [1:0] err;

  int checks = 0;
  int errors = 0;

  bsg_wormhole_router_input_control_vc #(
    .vc_p(2), .output_dirs_p(4), .payload_len_bits_p(5)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .fifo_v_i           (fifo_v),
    .fifo_decoded_dest_i(fifo_dest),
    .fifo_payload_len_i (fifo_len),
    .fifo_yumi_i        (fifo_yumi),
    .reqs_o             (reqs),
    .dest_r_o           (dest_r),
    .detected_header_o  (det),
    .release_o          (rel),
    .busy_o             (busy),
    .err_o              (err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst_n;
    logic [1:0] v;
    logic [7:0] dest;
    logic [9:0] len;
    logic [1:0] yumi;
    logic [7:0] e_reqs;
    logic [7:0] e_dest_r;
    logic [1:0] e_det;
    logic [1:0] e_rel;
    logic [1:0] e_busy;
    logic [1:0] e_err;
  } vec_t;

  vec_t vecs[$];

  // driver tasks
  task automatic drive(input logic r, input logic [1:0] v, input logic [7:0] d,
                       input logic [9:0] l, input logic [1:0] y);
    reset_n   = r;
    fifo_v    = v;
    fifo_dest = d;
    fifo_len  = l;
    fifo_yumi = y;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, " reqs"},   32'(reqs),   32'(e.e_reqs));
    chk({tag, " dest_r"}, 32'(dest_r), 32'(e.e_dest_r));
    chk({tag, " det"},    32'(det),    32'(e.e_det));
    chk({tag, " rel"},    32'(rel),    32'(e.e_rel));
    chk({tag, " busy"},   32'(busy),   32'(e.e_busy));
    chk({tag, " err"},    32'(err),    32'(e.e_err));
  endtask

  initial begin
    drive(1'b0, 2'b00, 8'h00, 10'h000, 2'b00);

    //            rst   v      dest   len      yumi   reqs   dest_r det    rel    busy   err
    // reset / idle
    vecs.push_back('{1'b0, 2'b00, 8'h00, 10'h000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{1'b0, 2'b00, 8'h00, 10'h000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00});
    // VC0 header dest=0100 len=3: request persists while not dequeued
    vecs.push_back('{1'b1, 2'b01, 8'h04, 10'h003, 2'b00, 8'h04, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{1'b1, 2'b01, 8'h04, 10'h003, 2'b01, 8'h04, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00});
    // body flits; dest/len inputs changed and must be ignored
    vecs.push_back('{1'b1, 2'b01, 8'h01, 10'h007, 2'b01, 8'h00, 8'h04, 2'b00, 2'b00, 2'b01, 2'b00});
    vecs.push_back('{1'b1, 2'b01, 8'h01, 10'h007, 2'b01, 8'h00, 8'h04, 2'b00, 2'b00, 2'b01, 2'b00});
    vecs.push_back('{1'b1, 2'b01, 8'h01, 10'h007, 2'b01, 8'h00, 8'h04, 2'b00, 2'b01, 2'b01, 2'b00});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 10'h000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00});
    // VC1 zero-length header dest=0001, then back-to-back header dest=1000 len=1
    vecs.push_back('{1'b1, 2'b10, 8'h10, 10'h000, 2'b10, 8'h10, 8'h00, 2'b10, 2'b10, 2'b00, 2'b00});
    vecs.push_back('{1'b1, 2'b10, 8'h80, 10'h020, 2'b10, 8'h80, 8'h00, 2'b10, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{1'b1, 2'b10, 8'h00, 10'h000, 2'b10, 8'h00, 8'h80, 2'b00, 2'b10, 2'b10, 2'b00});
    // interleaved: VC0 dest=0010 len=2, VC1 dest=0100 len=1
    vecs.push_back('{1'b1, 2'b11, 8'h42, 10'h022, 2'b11, 8'h42, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{1'b1, 2'b11, 8'h42, 10'h022, 2'b01, 8'h00, 8'h42, 2'b00, 2'b00, 2'b11, 2'b00});
    vecs.push_back('{1'b1, 2'b11, 8'h42, 10'h022, 2'b10, 8'h00, 8'h42, 2'b00, 2'b10, 2'b11, 2'b00});
    vecs.push_back('{1'b1, 2'b11, 8'h42, 10'h022, 2'b01, 8'h40, 8'h02, 2'b10, 2'b01, 2'b01, 2'b00});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 10'h000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00});
    // VC1 yumi without valid: error shows after the edge
    vecs.push_back('{1'b1, 2'b00, 8'h00, 10'h000, 2'b10, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00});
    vecs.push_back('{1'b1, 2'b00, 8'h00, 10'h000, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b10});

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].v, vecs[i].dest, vecs[i].len, vecs[i].yumi);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), vecs[i]);
      next_cycle();
    end

    // Max length on VC0 (dest=1000, len=31) with VC1 mid-packet (dest=0001,
    // len=2) receiving yumi without valid during VC0's body.
    drive(1'b1, 2'b11, 8'h18, 10'h05F, 2'b11);
    @(negedge clk);
    chk("max hdr reqs", 32'(reqs), 32'h18);
    chk("max hdr rel",  32'(rel),  32'h0);
    next_cycle();
    for (int k = 1; k <= 31; k++) begin
      drive(1'b1, 2'b01, 8'h00, 10'h000, 2'b11);
      @(negedge clk);
      chk($sformatf("max body%0d rel", k),    32'(rel),    (k == 31) ? 32'h1 : 32'h0);
      chk($sformatf("max body%0d busy", k),   32'(busy),   32'h3);
      chk($sformatf("max body%0d dest_r", k), 32'(dest_r), 32'h18);
      next_cycle();
    end
    drive(1'b1, 2'b00, 8'h00, 10'h000, 2'b00);
    @(negedge clk);
    chk("max done busy",   32'(busy),   32'h2);
    chk("max done dest_r", 32'(dest_r), 32'h10);
    chk("max done err",    32'(err),    32'h2);
    next_cycle();
    // VC1 counter must still be 2: release on its second accepted body flit
    drive(1'b1, 2'b10, 8'h00, 10'h000, 2'b10);
    @(negedge clk);
    chk("vc1 body1 rel",  32'(rel),  32'h0);
    chk("vc1 body1 busy", 32'(busy), 32'h2);
    next_cycle();
    @(negedge clk);
    chk("vc1 body2 rel",  32'(rel),  32'h2);
    chk("vc1 body2 err",  32'(err),  32'h2);
    next_cycle();

    // Reset mid-packet: VC0 header len=7 dest=0010, two body flits -> ctr=5
    drive(1'b1, 2'b01, 8'h02, 10'h007, 2'b01);
    next_cycle();
    next_cycle();
    next_cycle();
    drive(1'b0, 2'b01, 8'h02, 10'h007, 2'b01);
    @(negedge clk);
    chk("rst mid busy", 32'(busy), 32'h1);
    chk("rst mid rel",  32'(rel),  32'h0);
    next_cycle();
    drive(1'b1, 2'b01, 8'h02, 10'h007, 2'b00);
    @(negedge clk);
    chk("post rst busy",   32'(busy),   32'h0);
    chk("post rst dest_r", 32'(dest_r), 32'h0);
    chk("post rst det",    32'(det),    32'h1);
    chk("post rst reqs",   32'(reqs),   32'h02);
    chk("post rst err",    32'(err),    32'h0);
    chk("post rst rel",    32'(rel),    32'h0);
    next_cycle();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_wormhole_router_input_control_vc.md
Name: bsg_wormhole_router_input_control_vc

Overview:
Per-input-port wormhole control for a router input with multiple virtual channels (VCs). Each VC has its own input FIFO, payload counter, header detection and request generation. Unlike the single-channel control, each VC latches the header's destination and holds it through the packet body. Each VC also emits a one-cycle tail/release pulse when the last flit is dequeued, and flags handshake protocol violations. The block sits between the per-VC input FIFOs/route decoders and the per-output round-robin arbiters.

Parameters:
vc_p, 2, number of virtual channels (>=1)
output_dirs_p, 4, number of output directions; width of the one-hot destination
payload_len_bits_p, 5, width of the header payload-length field; maximum body length is 2^payload_len_bits_p - 1 flits

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_n_i  in  1  reset, synchronous, active-low
fifo_v_i  in  vc_p  per-VC FIFO head valid
fifo_decoded_dest_i  in  vc_p*output_dirs_p  per-VC one-hot destination of the head flit; VC v occupies slice [v*output_dirs_p +: output_dirs_p]
fifo_payload_len_i  in  vc_p*payload_len_bits_p  per-VC payload length of the head flit (meaningful on headers only)
fifo_yumi_i  in  vc_p  per-VC dequeue of the head flit this cycle
reqs_o  out  vc_p*output_dirs_p  per-VC output requests, asserted for header flits only
dest_r_o  out  vc_p*output_dirs_p  per-VC latched destination of the packet in flight; 0 when the VC is idle
detected_header_o  out  vc_p  head flit of the VC is a valid header
release_o  out  vc_p  one-cycle pulse: the tail flit of the VC is dequeued this cycle
busy_o  out  vc_p  VC is inside a packet body (counter nonzero)
err_o  out  vc_p  sticky protocol error flag

Behaviour:
- All VCs are fully independent; the only shared signals are the clock and reset.
- Reset (reset_n_i=0 at the clock edge) sets, for every VC: ctr_r=0, dest_r=0, err_r=0.
- Reset also aborts any in-flight packet; the next valid flit after reset is treated as a header.
- During reset the combinational outputs follow the current state, which is zero after the first reset edge.
- Per-VC state: ctr_r[payload_len_bits_p], dest_r[output_dirs_p], err_r.
  - idle when ctr_r==0.
  - busy_o = (ctr_r != 0).
- Header detection, combinational with zero latency: detected_header_o[v] = fifo_v_i[v] & (ctr_r==0).
- Requests: reqs_o slice = detected_header_o[v] ? fifo_decoded_dest_i slice : 0.
  - No requests are driven for body flits.
  - Requests persist every cycle until the header is dequeued.
- Accepted dequeue: acc = fifo_yumi_i[v] & fifo_v_i[v].
- Header accepted (acc & ctr_r==0):
  - ctr_r <= fifo_payload_len_i slice.
  - dest_r <= fifo_decoded_dest_i slice if the length is nonzero, else 0.
- Body flit accepted (acc & ctr_r!=0):
  - ctr_r <= ctr_r - 1, a plain decrement.
  - Underflow cannot occur because a decrement only happens when ctr_r != 0.
  - When ctr_r==1, dest_r <= 0 in the same cycle.
- release_o[v] = acc & ((ctr_r==0 & len==0) | ctr_r==1).
  - It is combinational and pulses in the cycle the tail is consumed.
  - A zero-length packet (header only) releases in its header cycle.
- Back-to-back packets: the cycle after a tail is consumed, ctr_r==0, so a valid head flit is immediately detected as a header. There are no bubble cycles.
- A maximum-length header (all ones) sets ctr_r to 2^payload_len_bits_p - 1 with no overflow.
- Protocol error: fifo_yumi_i[v] & ~fifo_v_i[v] sets err_r.
  - The flit is ignored: no counter or dest change, and release_o is 0.
  - err_o[v] = err_r stays set until reset.
- A header presented while another VC is mid-packet is handled normally; VCs interleave freely.
- fifo_payload_len_i is ignored when the VC is not idle.
- fifo_decoded_dest_i is ignored except at the header.

Test Plan:
- Reset/idle:
  - Stimulus: reset_n_i=0 for 2 cycles, then all inputs 0.
  - Required: reqs_o=0, dest_r_o=0, busy_o=0, release_o=0, err_o=0.
- Single packet on VC0:
  - Stimulus: fifo_v_i[0]=1, dest=4'b0100, len=3; yumi in 4 consecutive cycles.
  - Required: reqs_o[3:0]=0100 before the header yumi only.
  - Required: ctr sequence 3,2,1,0; dest_r_o[3:0]=0100 for 3 cycles.
  - Required: release_o[0] pulses on the 4th yumi; busy_o[0] is high for 3 cycles.
- Zero-length and back-to-back:
  - Stimulus: VC1 header dest=0001, len=0, yumi; next cycle header dest=1000, len=1.
  - Required: release_o[1] pulses in the first cycle with dest_r_o=0.
  - Required: the next cycle shows detected_header_o[1]=1 and reqs=1000.
- Interleaved VCs:
  - Stimulus: VC0 len=2 and VC1 len=1 started in the same cycle; yumis alternate.
  - Required: counters evolve independently; each release aligns with its own tail.
  - Required: no cross-VC request is ever driven.
- Max length and protocol error:
  - Stimulus: len=31 header on VC0, then 31 body yumis; also fifo_yumi_i[1]=1 with fifo_v_i[1]=0.
  - Required: release_o[0] fires on exactly the 32nd accepted flit.
  - Required: err_o[1]=1 and stays sticky; VC1 counter is unchanged.
- Reset mid-packet:
  - Stimulus: assert reset with VC0 at ctr=5.
  - Required: next cycle ctr=0, dest_r_o=0, no release pulse.
  - Required: the next valid flit is detected as a header.
